// File: rtl/bp_common_pkg.sv
// rtl/bp_common_pkg.sv - shared types and helpers for the multicore watchdog
package bp_common_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE, HUNG} bp_wdog_state_e;

   localparam logic e_wdog_heartbeat = 1'b0;
   localparam logic e_wdog_timeout   = 1'b1;

   // Counter/index width that never collapses to zero bits
   function automatic int wdog_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bp_wdog_core_monitor.sv
// rtl/bp_wdog_core_monitor.sv - one core's progress FSM, stall/retire counters and event bits
module bp_wdog_core_monitor
   import bp_common_pkg::*;
#(
   parameter int vaddr_width_p     = 39,
   parameter int timeout_cycles_p  = 100000,
   parameter int heartbeat_instr_p = 100000
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     freeze_i,
   input  logic [vaddr_width_p-1:0] npc_i,
   input  logic                     instret_i,
   input  logic                     finish_i,
   input  logic                     clr_hb_i,
   input  logic                     clr_to_i,
   output logic                     hb_pend_o,
   output logic                     to_pend_o,
   output logic                     timeout_o,
   output logic                     overrun_o,
   output logic                     done_o
);

   localparam int sw_lp = wdog_width(timeout_cycles_p);
   localparam int rw_lp = wdog_width(heartbeat_instr_p);
   localparam logic [sw_lp-1:0] stall_lim_lp = sw_lp'(timeout_cycles_p - 1);
   localparam logic [rw_lp-1:0] ret_lim_lp   = rw_lp'(heartbeat_instr_p - 1);

   bp_wdog_state_e           state_q, state_d;
   logic [vaddr_width_p-1:0] npc_q, npc_d;
   logic [sw_lp-1:0]         stall_q, stall_d;
   logic [rw_lp-1:0]         ret_q, ret_d;
   logic                     hb_q, hb_d, to_q, to_d, tof_q, tof_d, ov_q, ov_d, done_q, done_d;
   logic                     active, stalled, hb_set, to_set;

   assign active  = (state_q == RUN) && !freeze_i;
   assign stalled = (npc_i == npc_q) && !instret_i;

   always_comb begin
      state_d = state_q;
      npc_d   = npc_q;
      stall_d = stall_q;
      ret_d   = ret_q;
      tof_d   = tof_q;
      done_d  = done_q;
      hb_set  = 1'b0;
      to_set  = 1'b0;
      unique case (state_q)
         IDLE: begin
            npc_d   = npc_i;
            stall_d = '0;
            if (!freeze_i) state_d = RUN;
         end
         RUN: begin
            npc_d   = npc_i;
            stall_d = '0;
            // finish outranks both freeze and a hang maturing this cycle
            if (finish_i) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else if (freeze_i) begin
               state_d = IDLE;
            end else if (stalled) begin
               if (stall_q == stall_lim_lp) begin
                  state_d = HUNG;
                  to_set  = 1'b1;
                  tof_d   = 1'b1;
               end else begin
                  stall_d = stall_q + sw_lp'(1);
               end
            end
         end
         default: ;
      endcase
      if (active && instret_i) begin
         if (ret_q == ret_lim_lp) begin
            ret_d  = '0;
            hb_set = 1'b1;
         end else begin
            ret_d = ret_q + rw_lp'(1);
         end
      end
      // a new heartbeat landing on an unconsumed one is merged and flagged
      ov_d = ov_q | (hb_set & hb_q & ~clr_hb_i);
      hb_d = hb_set | (hb_q & ~clr_hb_i);
      to_d = to_set | (to_q & ~clr_to_i);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         npc_q   <= '0;
         stall_q <= '0;
         ret_q   <= '0;
         hb_q    <= 1'b0;
         to_q    <= 1'b0;
         tof_q   <= 1'b0;
         ov_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         npc_q   <= npc_d;
         stall_q <= stall_d;
         ret_q   <= ret_d;
         hb_q    <= hb_d;
         to_q    <= to_d;
         tof_q   <= tof_d;
         ov_q    <= ov_d;
         done_q  <= done_d;
      end
   end

   assign hb_pend_o = hb_q;
   assign to_pend_o = to_q;
   assign timeout_o = tof_q;
   assign overrun_o = ov_q;
   assign done_o    = done_q;

endmodule

// File: rtl/bsg_arb_round_robin.sv
// rtl/bsg_arb_round_robin.sv - round-robin arbiter; search starts after the last granted requester
module bsg_arb_round_robin
   import bp_common_pkg::*;
#(
   parameter int width_p = 4,
   localparam int tag_w_lp = wdog_width(width_p)
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic [width_p-1:0]  reqs_i,
   input  logic                yumi_i,
   output logic                v_o,
   output logic [tag_w_lp-1:0] tag_o
);

   logic [tag_w_lp-1:0] last_q;

   always_comb begin
      int idx;
      idx   = 0;
      v_o   = 1'b0;
      tag_o = '0;
      for (int i = 1; i <= width_p; i++) begin
         idx = (int'(last_q) + i) % width_p;
         if (!v_o && reqs_i[idx]) begin
            v_o   = 1'b1;
            tag_o = tag_w_lp'(idx);
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         last_q <= '0;
      end else if (v_o && yumi_i) begin
         last_q <= tag_o;
      end
   end

endmodule

// File: rtl/bp_multicore_watchdog.sv
// rtl/bp_multicore_watchdog.sv - per-core progress monitors merged into one arbitrated event stream
module bp_multicore_watchdog
   import bp_common_pkg::*;
#(
   parameter int num_core_p        = 4,
   parameter int vaddr_width_p     = 39,
   parameter int timeout_cycles_p  = 100000,
   parameter int heartbeat_instr_p = 100000,
   localparam int core_w_lp        = wdog_width(num_core_p)
) (
   input  logic                                clk_i,
   input  logic                                reset_n_i,
   input  logic [num_core_p-1:0]               freeze_i,
   input  logic [num_core_p*vaddr_width_p-1:0] npc_i,
   input  logic [num_core_p-1:0]               instret_i,
   input  logic [num_core_p-1:0]               finish_i,
   output logic                                event_v_o,
   input  logic                                event_ready_i,
   output logic [core_w_lp-1:0]                event_core_o,
   output logic                                event_type_o,
   output logic [num_core_p-1:0]               timeout_o,
   output logic [num_core_p-1:0]               overrun_o,
   output logic                                all_finish_o
);

   logic [num_core_p-1:0] hb_pend, to_pend, clr_hb, clr_to, done;
   logic [core_w_lp-1:0]  tag;
   logic                  arb_v, hs, sel_to;

   for (genvar k = 0; k < num_core_p; k++) begin : g_core
      bp_wdog_core_monitor #(
         .vaddr_width_p    (vaddr_width_p),
         .timeout_cycles_p (timeout_cycles_p),
         .heartbeat_instr_p(heartbeat_instr_p)
      ) u_mon (
         .clk_i    (clk_i),
         .reset_n_i(reset_n_i),
         .freeze_i (freeze_i[k]),
         .npc_i    (npc_i[k*vaddr_width_p +: vaddr_width_p]),
         .instret_i(instret_i[k]),
         .finish_i (finish_i[k]),
         .clr_hb_i (clr_hb[k]),
         .clr_to_i (clr_to[k]),
         .hb_pend_o(hb_pend[k]),
         .to_pend_o(to_pend[k]),
         .timeout_o(timeout_o[k]),
         .overrun_o(overrun_o[k]),
         .done_o   (done[k])
      );
   end

   bsg_arb_round_robin #(.width_p(num_core_p)) u_arb (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .reqs_i   (hb_pend | to_pend),
      .yumi_i   (hs),
      .v_o      (arb_v),
      .tag_o    (tag)
   );

   assign sel_to = to_pend[tag];
   assign hs     = arb_v & event_ready_i;

   // only the highest-ranked bit of the granted core is retired per handshake
   always_comb begin
      clr_hb = '0;
      clr_to = '0;
      if (hs) begin
         if (sel_to) clr_to[tag] = 1'b1;
         else        clr_hb[tag] = 1'b1;
      end
   end

   assign event_v_o    = arb_v;
   assign event_core_o = tag;
   assign event_type_o = sel_to ? e_wdog_timeout : e_wdog_heartbeat;
   assign all_finish_o = &done;

endmodule

// File: tb/tb_bp_multicore_watchdog.sv
// tb/tb_bp_multicore_watchdog.sv - directed table, random stimulus with reference model, async reset check
module tb_bp_multicore_watchdog;

   localparam int NC = 2;
   localparam int VW = 39;
   localparam int TO = 8;
   localparam int HB = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NC-1:0]    freeze, instret, finish, timeout_o, overrun_o;
   logic [NC*VW-1:0] npc;
   logic [VW-1:0]    npcs[NC];
   logic             ready, event_v_o, event_type_o, all_finish_o;
   logic [0:0]       event_core_o;

   always #5 clk = ~clk;

   always_comb for (int k = 0; k < NC; k++) npc[k*VW +: VW] = npcs[k];

   bp_multicore_watchdog #(
      .num_core_p(NC), .vaddr_width_p(VW), .timeout_cycles_p(TO), .heartbeat_instr_p(HB)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .npc_i(npc),
      .instret_i(instret), .finish_i(finish), .event_v_o(event_v_o),
      .event_ready_i(ready), .event_core_o(event_core_o), .event_type_o(event_type_o),
      .timeout_o(timeout_o), .overrun_o(overrun_o), .all_finish_o(all_finish_o)
   );

   int n_vec = 0, n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 frozen/waiting, 1 running, 2 finished, 3 hung
   int            m_mode[NC], m_stall[NC], m_ret[NC], m_ptr;
   logic [VW-1:0] m_last[NC];
   bit            m_hb[NC], m_to[NC], m_tof[NC], m_ov[NC], m_done[NC];

   task automatic m_reset();
      for (int k = 0; k < NC; k++) begin
         m_mode[k] = 0; m_stall[k] = 0; m_ret[k] = 0; m_last[k] = '0;
         m_hb[k] = 0; m_to[k] = 0; m_tof[k] = 0; m_ov[k] = 0; m_done[k] = 0;
      end
      m_ptr = 0;
   endtask

   task automatic m_outs(output bit v, output int g, output bit t);
      v = 0; g = 0; t = 0;
      for (int i = 1; i <= NC; i++) begin
         int k;
         k = (m_ptr + i) % NC;
         if (!v && (m_hb[k] || m_to[k])) begin
            v = 1; g = k; t = m_to[k];
         end
      end
   endtask

   task automatic m_step();
      bit v, t, hs;
      int g;
      m_outs(v, g, t);
      hs = v && ready;
      if (hs) m_ptr = g;
      for (int k = 0; k < NC; k++) begin
         bit clr_hb, clr_to, hb_set, to_set;
         clr_hb = hs && (g == k) && !t;
         clr_to = hs && (g == k) && t;
         hb_set = 0; to_set = 0;
         if (m_mode[k] == 0) begin
            m_last[k] = npcs[k]; m_stall[k] = 0;
            if (!freeze[k]) m_mode[k] = 1;
         end else if (m_mode[k] == 1) begin
            if (!freeze[k] && instret[k]) begin
               m_ret[k] = (m_ret[k] + 1) % HB;
               if (m_ret[k] == 0) begin
                  hb_set = 1;
                  if (m_hb[k] && !clr_hb) m_ov[k] = 1;
               end
            end
            if (finish[k]) begin
               m_mode[k] = 2; m_done[k] = 1;
            end else if (freeze[k]) begin
               m_mode[k] = 0; m_stall[k] = 0;
            end else if (npcs[k] == m_last[k] && !instret[k]) begin
               m_stall[k]++;
               if (m_stall[k] == TO) begin
                  m_mode[k] = 3; m_tof[k] = 1; to_set = 1;
               end
            end else begin
               m_stall[k] = 0;
            end
            m_last[k] = npcs[k];
         end
         m_hb[k] = hb_set || (m_hb[k] && !clr_hb);
         m_to[k] = to_set || (m_to[k] && !clr_to);
      end
   endtask

   task automatic model_check();
      bit v, t, af;
      int g;
      logic [NC-1:0] eto, eov;
      m_outs(v, g, t);
      af = 1;
      for (int k = 0; k < NC; k++) begin
         eto[k] = m_tof[k]; eov[k] = m_ov[k]; af &= m_done[k];
      end
      chk("model_v", event_v_o, v);
      if (v) begin
         chk("model_core", event_core_o, g);
         chk("model_type", event_type_o, t);
      end
      chk("model_timeout", timeout_o, eto);
      chk("model_overrun", overrun_o, eov);
      chk("model_all_finish", all_finish_o, af);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_v"}, event_v_o, 0);
      chk({tag, "_core"}, event_core_o, 0);
      chk({tag, "_type"}, event_type_o, 0);
      chk({tag, "_timeout"}, timeout_o, 0);
      chk({tag, "_overrun"}, overrun_o, 0);
      chk({tag, "_all_finish"}, all_finish_o, 0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check_zero("reset");
      m_reset();
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic sample();
      @(negedge clk);
      model_check();
   endtask

   task automatic advance();
      @(posedge clk);
      m_step();
      #1;
   endtask

   typedef struct {
      bit       rst;
      bit [1:0] frz, ret, fin, inc;
      bit       rdy;
      int       n;
      bit       ev;
      int       core;
      bit       typ;
      bit [1:0] to, ov;
      bit       af;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rst, bit [1:0] frz, bit [1:0] ret, bit [1:0] fin, bit [1:0] inc,
                               bit rdy, int n, bit ev, int core, bit typ, bit [1:0] to,
                               bit [1:0] ov, bit af);
      vec_t r;
      r.rst = rst; r.frz = frz; r.ret = ret; r.fin = fin; r.inc = inc; r.rdy = rdy; r.n = n;
      r.ev = ev; r.core = core; r.typ = typ; r.to = to; r.ov = ov; r.af = af;
      return r;
   endfunction

   initial begin
      bit stall_mode[NC];
      bit async_done;
      reset_n = 1'b1;
      freeze = '1; instret = '0; finish = '0; ready = 1'b0;
      for (int k = 0; k < NC; k++) npcs[k] = VW'(32'h1000 + k * 32'h100);
      #2;

      //        rst frz    ret    fin    inc    rdy n   ev core typ to     ov     af
      tbl.push_back(mk(1, 2'b11, 2'b00, 2'b00, 2'b00, 0, 20, 0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 9,  0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 1,  1, 0, 1, 2'b01, 2'b00, 0));
      tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 1, 1,  1, 0, 1, 2'b01, 2'b00, 0));
      tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 1,  0, 0, 0, 2'b01, 2'b00, 0));
      tbl.push_back(mk(1, 2'b01, 2'b00, 2'b00, 2'b11, 1, 1,  0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b01, 2'b10, 2'b00, 2'b11, 1, 4,  0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b11, 1, 1,  1, 1, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b11, 1, 1,  0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b00, 2'b11, 2'b00, 2'b11, 1, 4,  0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b11, 1, 1,  1, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b11, 1, 1,  1, 1, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b11, 1, 1,  0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b00, 2'b10, 2'b00, 2'b11, 0, 8,  1, 1, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b11, 0, 1,  1, 1, 0, 2'b00, 2'b10, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b11, 1, 1,  1, 1, 0, 2'b00, 2'b10, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b11, 1, 1,  0, 0, 0, 2'b00, 2'b10, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 2'b11, 1, 1,  0, 0, 0, 2'b00, 2'b10, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b11, 1, 1,  0, 0, 0, 2'b00, 2'b10, 1));

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         for (int j = 0; j < tbl[i].n; j++) begin
            for (int k = 0; k < NC; k++) if (tbl[i].inc[k]) npcs[k] = npcs[k] + VW'(4);
            freeze = tbl[i].frz; instret = tbl[i].ret; finish = tbl[i].fin; ready = tbl[i].rdy;
            sample();
            if (j == tbl[i].n - 1) begin
               chk($sformatf("tbl%0d_v", i), event_v_o, tbl[i].ev);
               if (tbl[i].ev) begin
                  chk($sformatf("tbl%0d_core", i), event_core_o, tbl[i].core);
                  chk($sformatf("tbl%0d_type", i), event_type_o, tbl[i].typ);
               end
               chk($sformatf("tbl%0d_timeout", i), timeout_o, tbl[i].to);
               chk($sformatf("tbl%0d_overrun", i), overrun_o, tbl[i].ov);
               chk($sformatf("tbl%0d_all_finish", i), all_finish_o, tbl[i].af);
            end
            advance();
         end
      end

      async_done = 0;
      for (int r = 0; r < 3; r++) begin
         do_reset();
         for (int k = 0; k < NC; k++) stall_mode[k] = 0;
         for (int i = 0; i < 300; i++) begin
            if (r == 1 && i > 100 && !async_done && event_v_o) begin
               reset_n = 1'b0;
               #1;
               check_zero("async_reset");
               m_reset();
               @(posedge clk);
               #1 reset_n = 1'b1;
               async_done = 1;
            end
            for (int k = 0; k < NC; k++) begin
               if (i % 24 == 0) stall_mode[k] = ($urandom_range(0, 2) == 0);
               freeze[k] = ($urandom_range(0, 15) == 0);
               finish[k] = ($urandom_range(0, 199) == 0);
               if (stall_mode[k]) begin
                  instret[k] = 1'b0;
               end else begin
                  instret[k] = 1'($urandom_range(0, 1));
                  if ($urandom_range(0, 1) == 1) npcs[k] = npcs[k] + VW'(4);
               end
            end
            ready = 1'($urandom_range(0, 1));
            sample();
            advance();
         end
      end
      chk("async_reset_reached", async_done, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
